// File: rtl/interrupt_ack_sequencer.sv
// Interrupt acknowledge sequencer for an 8259A-style controller.
// Resolves the highest rotated-priority unmasked request, applies the fully
// nested rule against the ISR, raises INT, tracks the two-pulse INTA
// handshake, and issues ISR set/clear strobes and the interrupt vector.
//
// Optional feature macro: AUTO_EOI_EN. When defined, auto_eoi = 1 clears the
// serviced level at the second INTA rise. When undefined, auto_eoi is ignored.
//
// Ports:
//   clock                   sole clock, rising edge
//   reset_n                 asynchronous active-low reset
//   interrupt_request[7:0]  latched IR levels (IRR)
//   interrupt_mask[7:0]     IMR, 1 masks a level
//   in_service_register[7:0] current ISR contents
//   priority_rotate[2:0]    lowest-priority level
//   interrupt_acknowledge_n INTA, pre-synchronized, active low
//   vector_base[4:0]        vector bits T7..T3
//   eoi_request             one-cycle non-specific EOI command
//   auto_eoi                AEOI mode bit
//   interrupt               INT to CPU
//   latch_in_service        one-cycle strobe to the ISR block
//   in_service_set[7:0]     one-hot level to set in ISR
//   end_of_interrupt[7:0]   one-hot level to clear in ISR
//   vector_out[7:0]         {vector_base, level}
//   vector_valid            vector_out drive enable
module interrupt_ack_sequencer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] interrupt_request,
  input  logic [7:0] interrupt_mask,
  input  logic [7:0] in_service_register,
  input  logic [2:0] priority_rotate,
  input  logic       interrupt_acknowledge_n,
  input  logic [4:0] vector_base,
  input  logic       eoi_request,
  input  logic       auto_eoi,
  output logic       interrupt,
  output logic       latch_in_service,
  output logic [7:0] in_service_set,
  output logic [7:0] end_of_interrupt,
  output logic [7:0] vector_out,
  output logic       vector_valid
);

  localparam int unsigned LVL_W = 3;
  localparam int unsigned NUM_LVL = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ACK1 = 2'd2;
  localparam logic [1:0] ST_ACK2 = 2'd3;

  // Highest rotated-priority set bit: {found, level}.
  function automatic logic [LVL_W:0] top_level(input logic [NUM_LVL-1:0] vec,
                                               input logic [LVL_W-1:0] rot);
    logic [LVL_W:0]   res;
    logic [LVL_W-1:0] lvl;
    res = '0;
    // Walk from lowest to highest priority so the highest one wins last.
    for (int i = NUM_LVL - 1; i >= 0; i--) begin
      lvl = rot + LVL_W'(i) + LVL_W'(1);
      if (vec[lvl]) res = {1'b1, lvl};
    end
    return res;
  endfunction

  // Priority rank of a level, 0 = highest.
  function automatic logic [LVL_W-1:0] rank(input logic [LVL_W-1:0] lvl,
                                            input logic [LVL_W-1:0] rot);
    return lvl - rot - LVL_W'(1);
  endfunction

  logic [1:0]       state, state_nxt;
  logic             inta_q;
  logic [LVL_W-1:0] lvl_q, lvl_nxt;
  logic             int_nxt, lis_nxt, vv_nxt;
  logic [7:0]       iss_nxt, eoi_nxt, vo_nxt;
  logic [LVL_W:0]   cand, isr_top;
  logic             eligible, inta_fall, inta_rise;

  assign cand      = top_level(interrupt_request & ~interrupt_mask, priority_rotate);
  assign isr_top   = top_level(in_service_register, priority_rotate);
  assign eligible  = cand[LVL_W] &&
                     (!isr_top[LVL_W] ||
                      (rank(cand[LVL_W-1:0], priority_rotate) <
                       rank(isr_top[LVL_W-1:0], priority_rotate)));
  assign inta_fall = inta_q & ~interrupt_acknowledge_n;
  assign inta_rise = ~inta_q & interrupt_acknowledge_n;

`ifdef AUTO_EOI_EN
  logic spur_q, spur_nxt;
`else
  logic unused_auto_eoi;
  assign unused_auto_eoi = auto_eoi;
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_nxt = state;
    lvl_nxt   = lvl_q;
    int_nxt   = interrupt;
    lis_nxt   = 1'b0;
    iss_nxt   = 8'd0;
    eoi_nxt   = 8'd0;
    vo_nxt    = vector_out;
    vv_nxt    = vector_valid;
`ifdef AUTO_EOI_EN
    spur_nxt  = spur_q;
`endif

    if (eoi_request && isr_top[LVL_W]) eoi_nxt = 8'd1 << isr_top[LVL_W-1:0];

    case (state)
      ST_IDLE: begin
        if (eligible) begin
          state_nxt = ST_REQ;
          int_nxt   = 1'b1;
        end
      end
      ST_REQ: begin
        // INT holds even if the request vanished; resolved at the INTA fall.
        if (inta_fall) begin
          state_nxt = ST_ACK1;
          int_nxt   = 1'b0;
          if (eligible) begin
            lvl_nxt = cand[LVL_W-1:0];
            lis_nxt = 1'b1;
            iss_nxt = 8'd1 << cand[LVL_W-1:0];
`ifdef AUTO_EOI_EN
            spur_nxt = 1'b0;
`endif
          end else begin
            lvl_nxt = LVL_W'(NUM_LVL - 1);
`ifdef AUTO_EOI_EN
            spur_nxt = 1'b1;
`endif
          end
        end
      end
      ST_ACK1: begin
        if (inta_rise) state_nxt = ST_ACK2;
      end
      ST_ACK2: begin
        if (inta_fall) begin
          vv_nxt = 1'b1;
          vo_nxt = {vector_base, lvl_q};
        end else if (inta_rise) begin
          vv_nxt    = 1'b0;
          vo_nxt    = 8'd0;
          state_nxt = ST_IDLE;
`ifdef AUTO_EOI_EN
          if (auto_eoi && !spur_q) eoi_nxt = eoi_nxt | (8'd1 << lvl_q);
`endif
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      inta_q           <= 1'b1;
      lvl_q            <= '0;
      interrupt        <= 1'b0;
      latch_in_service <= 1'b0;
      in_service_set   <= 8'd0;
      end_of_interrupt <= 8'd0;
      vector_out       <= 8'd0;
      vector_valid     <= 1'b0;
`ifdef AUTO_EOI_EN
      spur_q           <= 1'b0;
`endif
    end else begin
      state            <= state_nxt;
      inta_q           <= interrupt_acknowledge_n;
      lvl_q            <= lvl_nxt;
      interrupt        <= int_nxt;
      latch_in_service <= lis_nxt;
      in_service_set   <= iss_nxt;
      end_of_interrupt <= eoi_nxt;
      vector_out       <= vo_nxt;
      vector_valid     <= vv_nxt;
`ifdef AUTO_EOI_EN
      spur_q           <= spur_nxt;
`endif
    end
  end

endmodule

// File: doc/interrupt_ack_sequencer.md
INTERRUPT_ACK_SEQUENCER -- requirements
Module: interrupt_ack_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports as follows (clock and reset first).
REQ-002 clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 interrupt_request  in  8  latched IR levels (IRR).
REQ-005 interrupt_mask  in  8  IMR; a 1 masks the level.
REQ-006 in_service_register  in  8  current ISR contents.
REQ-007 priority_rotate  in  3  lowest-priority level; level (priority_rotate+1) mod 8 is highest.
REQ-008 interrupt_acknowledge_n  in  1  INTA, pre-synchronized, active low.
REQ-009 vector_base  in  5  ICW2 T7..T3.
REQ-010 eoi_request  in  1  one-cycle non-specific EOI command.
REQ-011 auto_eoi  in  1  AEOI mode bit from ICW4.
REQ-012 interrupt  out  1  INT to CPU.
REQ-013 latch_in_service  out  1  one-cycle strobe to the ISR block.
REQ-014 in_service_set  out  8  one-hot level to set in ISR; valid with latch_in_service, else 0.
REQ-015 end_of_interrupt  out  8  one-hot level to clear in ISR; one cycle, else 0.
REQ-016 vector_out  out  8  {vector_base, level}.
REQ-017 vector_valid  out  1  vector_out drive enable.

Function
REQ-018 Candidate: highest rotated-priority bit of interrupt_request & ~interrupt_mask, combinational.
REQ-019 Fully nested rule: a candidate is eligible only if its priority is strictly higher than the highest set bit of in_service_register, or if in_service_register is 0.
REQ-020 INTA edges: detect falls and rises on interrupt_acknowledge_n against a registered copy; edges are one-cycle events.
REQ-021 FSM states: IDLE, REQ, ACK1, ACK2.
REQ-022 IDLE: on an eligible candidate, go to REQ; interrupt is 1 from the next cycle.
REQ-023 REQ: on an INTA fall, go to ACK1 and latch the level.
REQ-024 REQ, first INTA fall with a valid candidate: pulse latch_in_service and in_service_set one cycle after the fall.
REQ-025 REQ, first INTA fall with no candidate (request withdrawn): treat as spurious; latch level 7; no latch_in_service pulse.
REQ-026 REQ: interrupt drops in the cycle latch_in_service pulses, or at the spurious fall.
REQ-027 REQ, candidate lost before INTA: interrupt stays 1 (8259A behaviour).
REQ-028 ACK1: on an INTA rise, go to ACK2.
REQ-029 ACK2: on an INTA fall, vector_out = {vector_base, latched level} and vector_valid = 1 while INTA is low.
REQ-030 ACK2: on the next INTA rise, vector_valid = 0 and the FSM returns to IDLE.
REQ-031 eoi_request: end_of_interrupt = one-hot of the highest rotated-priority set bit of in_service_register, next cycle, one cycle; 0 if the ISR is empty.
REQ-032 Simultaneous eoi_request and latch_in_service: both are produced independently in the same cycle.
REQ-033 Back-to-back: a new request is evaluated in the cycle after the return to IDLE.

Reset
REQ-034 On reset_n low, the FSM goes to IDLE immediately and all outputs become 0, including vector_out = 8'h00; reset mid-handshake abandons the cycle without any EOI.

Configuration
REQ-035 With macro AUTO_EOI_EN defined and auto_eoi = 1, end_of_interrupt pulses the latched one-hot level for one cycle at the second INTA rise; spurious level 7 produces no pulse.
REQ-036 With AUTO_EOI_EN undefined, auto_eoi is ignored and no automatic EOI logic is synthesized.

Verification
REQ-037 IRR=8'h04, IMR=0, ISR=0, rotate=7, two INTA pulses, base=5'h08 -> interrupt rises, in_service_set=8'h04 strobe, vector_out=8'h42, return to IDLE.
REQ-038 IRR=8'h21, rotate=2 -> level 5 wins: in_service_set=8'h20, vector low bits 3'b101.
REQ-039 ISR=8'h02, IRR=8'h08, rotate=7 -> interrupt stays 0; then eoi_request -> end_of_interrupt=8'h02, then interrupt rises.
REQ-040 Assert IRR=8'h01, drop it before the first INTA -> no latch_in_service; vector low bits 3'b111.
REQ-041 AUTO_EOI_EN defined, auto_eoi=1, IRR=8'h10 -> end_of_interrupt=8'h10 one cycle at the second INTA rise; without the macro, stays 0.
REQ-042 reset_n pulsed low in ACK1 -> all outputs 0 immediately, FSM in IDLE, no end_of_interrupt.
